// File: rtl/rename_reg_file_if.sv
// Bundled rename / commit / flush / read signals of rename_reg_file.
// Checkpoint controls exist only when RRF_CHECKPOINT_EN is defined.
interface rename_reg_file_if #(
    parameter int NUM_READ       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_ADDR_WIDTH = 5
) ();
    logic                           ren_en;
    logic [4:0]                     ren_addr;
    logic [ROB_ADDR_WIDTH-1:0]      ren_id;
    logic                           cmt_en;
    logic [4:0]                     cmt_addr;
    logic [ROB_ADDR_WIDTH-1:0]      cmt_id;
    logic [DATA_WIDTH-1:0]          cmt_data;
    logic                           flush;
    logic [NUM_READ-1:0]            rd_en;
    logic [5*NUM_READ-1:0]          rd_addr;
    logic [NUM_READ-1:0]            rd_is_ref;
    logic [DATA_WIDTH*NUM_READ-1:0] rd_data;
    logic [5:0]                     ref_count;
`ifdef RRF_CHECKPOINT_EN
    logic                           ckpt_save;
    logic                           ckpt_restore;
`endif

    modport master (
        output ren_en, ren_addr, ren_id,
        output cmt_en, cmt_addr, cmt_id, cmt_data,
        output flush, rd_en, rd_addr,
`ifdef RRF_CHECKPOINT_EN
        output ckpt_save, ckpt_restore,
`endif
        input  rd_is_ref, rd_data, ref_count
    );

    modport slave (
        input  ren_en, ren_addr, ren_id,
        input  cmt_en, cmt_addr, cmt_id, cmt_data,
        input  flush, rd_en, rd_addr,
`ifdef RRF_CHECKPOINT_EN
        input  ckpt_save, ckpt_restore,
`endif
        output rd_is_ref, rd_data, ref_count
    );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags (pending ROB id per register).
// Optional single checkpoint of the rename table: define RRF_CHECKPOINT_EN.
module rename_reg_file #(
    parameter int NUM_READ       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    rename_reg_file_if.slave   bus
);
    localparam int RW = ROB_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]          r_value [32];
    logic [31:0]                    r_is_ref;
    logic [RW-1:0]                  r_ref_id [32];
    logic [5:0]                     r_ref_count;

    logic [31:0]                    w_is_ref_nxt;
    logic [RW-1:0]                  w_ref_id_nxt [32];
    logic                           w_ren_ok;
    logic                           w_cmt_ok;
    logic                           w_cmt_hit;
    logic [NUM_READ-1:0]            w_rd_is_ref;
    logic [DATA_WIDTH*NUM_READ-1:0] w_rd_data;

`ifdef RRF_CHECKPOINT_EN
    logic [31:0]                    r_sh_is_ref;
    logic [RW-1:0]                  r_sh_ref_id [32];
    logic [31:0]                    w_sh_is_ref_nxt;
    logic                           w_recover;
`endif

    function automatic logic [DATA_WIDTH-1:0] zext(input logic [RW-1:0] id);
        zext = {{(DATA_WIDTH-RW){1'b0}}, id};
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int k = 0; k < 32; k++) begin
            cnt = cnt + {5'd0, v[k]};
        end
        return cnt;
    endfunction

    assign w_ren_ok  = bus.ren_en && (bus.ren_addr != 5'd0);
    assign w_cmt_ok  = bus.cmt_en && (bus.cmt_addr != 5'd0);
    assign w_cmt_hit = w_cmt_ok && r_is_ref[bus.cmt_addr] && (r_ref_id[bus.cmt_addr] == bus.cmt_id);

`ifdef RRF_CHECKPOINT_EN
    assign w_recover = bus.flush || bus.ckpt_restore;

    // Shadow table retires its own pending tags on matching commits.
    always_comb begin
        w_sh_is_ref_nxt = r_sh_is_ref;
        if (w_cmt_ok && r_sh_is_ref[bus.cmt_addr] && (r_sh_ref_id[bus.cmt_addr] == bus.cmt_id)) begin
            w_sh_is_ref_nxt[bus.cmt_addr] = 1'b0;
        end else begin
            w_sh_is_ref_nxt = r_sh_is_ref;
        end
    end
`endif

    // Next rename table: commit clears, then recovery, then rename wins.
    always_comb begin
        w_is_ref_nxt = r_is_ref;
        w_ref_id_nxt = r_ref_id;
        if (w_cmt_hit) begin
            w_is_ref_nxt[bus.cmt_addr] = 1'b0;
        end else begin
            w_is_ref_nxt = r_is_ref;
        end
`ifdef RRF_CHECKPOINT_EN
        if (bus.ckpt_restore) begin
            w_is_ref_nxt = w_sh_is_ref_nxt;
            w_ref_id_nxt = r_sh_ref_id;
        end else if (bus.flush) begin
`else
        if (bus.flush) begin
`endif
            w_is_ref_nxt = 32'd0;
        end else if (w_ren_ok) begin
            w_is_ref_nxt[bus.ren_addr] = 1'b1;
            w_ref_id_nxt[bus.ren_addr] = bus.ren_id;
        end else begin
            w_ref_id_nxt = w_ref_id_nxt;
        end
    end

    // State registers; commit data lands even during a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_ref    <= 32'd0;
            r_ref_count <= 6'd0;
            for (int k = 0; k < 32; k++) begin
                r_value[k]  <= '0;
                r_ref_id[k] <= '0;
            end
        end else begin
            r_is_ref    <= w_is_ref_nxt;
            r_ref_id    <= w_ref_id_nxt;
            r_ref_count <= popcount(w_is_ref_nxt);
            if (w_cmt_ok) begin
                r_value[bus.cmt_addr] <= bus.cmt_data;
            end
        end
    end

`ifdef RRF_CHECKPOINT_EN
    // Shadow captures the table as it will look after this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh_is_ref <= 32'd0;
            for (int k = 0; k < 32; k++) begin
                r_sh_ref_id[k] <= '0;
            end
        end else if (bus.ckpt_save) begin
            r_sh_is_ref <= w_is_ref_nxt;
            r_sh_ref_id <= w_ref_id_nxt;
        end else begin
            r_sh_is_ref <= w_sh_is_ref_nxt;
        end
    end
`endif

    // Zero-latency read ports with same-cycle forwarding.
    always_comb begin
        logic [4:0] w_a;
        w_rd_is_ref = '0;
        w_rd_data   = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_a = bus.rd_addr[i*5 +: 5];
            if (!rst || !bus.rd_en[i] || (w_a == 5'd0)) begin
                w_rd_is_ref[i] = 1'b0;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
`ifdef RRF_CHECKPOINT_EN
            end else if (bus.ckpt_restore) begin
                if (w_cmt_ok && (bus.cmt_addr == w_a) && r_sh_is_ref[w_a] && (r_sh_ref_id[w_a] == bus.cmt_id)) begin
                    w_rd_is_ref[i] = 1'b0;
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.cmt_data;
                end else if (r_sh_is_ref[w_a]) begin
                    w_rd_is_ref[i] = 1'b1;
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = zext(r_sh_ref_id[w_a]);
                end else if (w_cmt_ok && (bus.cmt_addr == w_a)) begin
                    w_rd_is_ref[i] = 1'b0;
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.cmt_data;
                end else begin
                    w_rd_is_ref[i] = 1'b0;
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_value[w_a];
                end
`endif
            end else if (bus.flush) begin
                w_rd_is_ref[i] = 1'b0;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    (w_cmt_ok && (bus.cmt_addr == w_a)) ? bus.cmt_data : r_value[w_a];
            end else if (w_ren_ok && (bus.ren_addr == w_a)) begin
                w_rd_is_ref[i] = 1'b1;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = zext(bus.ren_id);
            end else if (w_cmt_hit && (bus.cmt_addr == w_a)) begin
                w_rd_is_ref[i] = 1'b0;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.cmt_data;
            end else if (r_is_ref[w_a]) begin
                w_rd_is_ref[i] = 1'b1;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = zext(r_ref_id[w_a]);
            end else begin
                w_rd_is_ref[i] = 1'b0;
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_value[w_a];
            end
        end
    end

    assign bus.rd_is_ref = w_rd_is_ref;
    assign bus.rd_data   = w_rd_data;
    assign bus.ref_count = r_ref_count;
endmodule

// File: tb/tb_rename_reg_file.sv
// Directed scoreboard bench for rename_reg_file; expectations queued by stimulus,
// popped by a negedge monitor.
module tb_rename_reg_file;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct {
        int          step;
        int          port;     // -1 marks a ref_count expectation
        logic        is_ref;
        logic [DW-1:0] data;
        logic [5:0]  rc;
    } exp_t;

    logic clk;
    logic rst;
    logic chk_rc;
    int   step;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t m_e;

    rename_reg_file_if #(.NUM_READ(NR), .DATA_WIDTH(DW), .ROB_ADDR_WIDTH(RW)) bus ();

    rename_reg_file #(.NUM_READ(NR), .DATA_WIDTH(DW), .ROB_ADDR_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.ren_en   = 1'b0;
        bus.ren_addr = 5'd0;
        bus.ren_id   = 5'd0;
        bus.cmt_en   = 1'b0;
        bus.cmt_addr = 5'd0;
        bus.cmt_id   = 5'd0;
        bus.cmt_data = 32'd0;
        bus.flush    = 1'b0;
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
`ifdef RRF_CHECKPOINT_EN
        bus.ckpt_save    = 1'b0;
        bus.ckpt_restore = 1'b0;
`endif
        chk_rc = 1'b0;
    endtask

    task automatic ren(input logic [4:0] a, input logic [4:0] id);
        bus.ren_en = 1'b1; bus.ren_addr = a; bus.ren_id = id;
    endtask

    task automatic cmt(input logic [4:0] a, input logic [4:0] id, input logic [31:0] d);
        bus.cmt_en = 1'b1; bus.cmt_addr = a; bus.cmt_id = id; bus.cmt_data = d;
    endtask

    // Enable read port p at address a and queue its expected response (push in port order).
    task automatic rd(input int p, input logic [4:0] a, input logic r, input logic [31:0] d);
        exp_t e;
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*5 +: 5] = a;
        e.step = step; e.port = p; e.is_ref = r; e.data = d; e.rc = 6'd0;
        sb.push_back(e);
    endtask

    task automatic exp_rc(input logic [5:0] v);
        exp_t e;
        e.step = step; e.port = -1; e.is_ref = 1'b0; e.data = 32'd0; e.rc = v;
        sb.push_back(e);
        chk_rc = 1'b1;
    endtask

    // Monitor: every enabled read port presents a response each cycle.
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            if (bus.rd_en[p]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rd_port%0d: output present with no expectation queued", p);
                end else begin
                    m_e = sb.pop_front();
                    if (m_e.port != p || bus.rd_is_ref[p] !== m_e.is_ref ||
                        bus.rd_data[p*DW +: DW] !== m_e.data) begin
                        errors++;
                        $display("FAIL rd_step%0d_port%0d: got is_ref=%0b data=%h, want port%0d is_ref=%0b data=%h",
                                 m_e.step, p, bus.rd_is_ref[p], bus.rd_data[p*DW +: DW],
                                 m_e.port, m_e.is_ref, m_e.data);
                    end
                end
            end else begin
                checks++;
                if (bus.rd_is_ref[p] !== 1'b0 || bus.rd_data[p*DW +: DW] !== 32'd0) begin
                    errors++;
                    $display("FAIL rd_disabled_port%0d: got is_ref=%0b data=%h, want 0 0",
                             p, bus.rd_is_ref[p], bus.rd_data[p*DW +: DW]);
                end
            end
        end
        if (chk_rc) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ref_count: no expectation queued, got %0d", bus.ref_count);
            end else begin
                m_e = sb.pop_front();
                if (m_e.port != -1 || bus.ref_count !== m_e.rc) begin
                    errors++;
                    $display("FAIL ref_count_step%0d: got %0d, want %0d", m_e.step, bus.ref_count, m_e.rc);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        step   = 0;
        rst    = 1'b0;
        clr();

        // Reset: reads forced to zero, rename ignored
        tick(); step = 0; clr();
        ren(5'd3, 5'd7);
        for (int p = 0; p < NR; p++) rd(p, 5'd5, 1'b0, 32'd0);
        exp_rc(6'd0);
        tick(); step = 1; clr(); rst = 1'b1;
        rd(0, 5'd3, 1'b0, 32'd0);
        for (int p = 1; p < NR; p++) rd(p, 5'd5, 1'b0, 32'd0);
        exp_rc(6'd0);

        // Rename r3 id7, then commit it
        tick(); step = 2; clr(); ren(5'd3, 5'd7); rd(0, 5'd3, 1'b1, 32'd7); exp_rc(6'd0);
        tick(); step = 3; clr(); rd(1, 5'd3, 1'b1, 32'd7); exp_rc(6'd1);
        tick(); step = 4; clr(); cmt(5'd3, 5'd7, 32'hDEAD); rd(2, 5'd3, 1'b0, 32'hDEAD); exp_rc(6'd1);
        tick(); step = 5; clr(); rd(0, 5'd3, 1'b0, 32'hDEAD); exp_rc(6'd0);

        // Stale commit leaves newer tag in place
        tick(); step = 6; clr(); ren(5'd4, 5'd2);
        tick(); step = 7; clr(); ren(5'd4, 5'd9); exp_rc(6'd1);
        tick(); step = 8; clr(); cmt(5'd4, 5'd2, 32'h11); rd(0, 5'd4, 1'b1, 32'd9); exp_rc(6'd1);
        tick(); step = 9; clr(); rd(1, 5'd4, 1'b1, 32'd9); exp_rc(6'd1);

        // Same-cycle rename and matching commit: rename wins the tag, value still written
        tick(); step = 10; clr(); ren(5'd4, 5'd12); cmt(5'd4, 5'd9, 32'h22); rd(3, 5'd4, 1'b1, 32'd12);
        tick(); step = 11; clr(); rd(0, 5'd4, 1'b1, 32'd12); exp_rc(6'd1);

        // Flush with a same-cycle commit and discarded rename
        tick(); step = 12; clr(); ren(5'd1, 5'd1);
        tick(); step = 13; clr(); ren(5'd2, 5'd3); exp_rc(6'd2);
        tick(); step = 14; clr(); ren(5'd3, 5'd4); exp_rc(6'd3);
        tick(); step = 15; clr(); bus.flush = 1'b1; cmt(5'd2, 5'd3, 32'h55); ren(5'd6, 5'd5);
        rd(0, 5'd1, 1'b0, 32'd0); rd(1, 5'd2, 1'b0, 32'h55);
        rd(2, 5'd3, 1'b0, 32'hDEAD); rd(3, 5'd6, 1'b0, 32'd0); exp_rc(6'd4);
        tick(); step = 16; clr();
        rd(0, 5'd1, 1'b0, 32'd0); rd(1, 5'd2, 1'b0, 32'h55);
        rd(2, 5'd3, 1'b0, 32'hDEAD); rd(3, 5'd6, 1'b0, 32'd0); exp_rc(6'd0);
        tick(); step = 17; clr(); ren(5'd7, 5'd6); rd(0, 5'd4, 1'b0, 32'h22); rd(1, 5'd7, 1'b1, 32'd6); exp_rc(6'd0);

        // Register 0 ignores rename and commit
        tick(); step = 18; clr(); ren(5'd0, 5'd3); cmt(5'd0, 5'd3, 32'hFF); rd(3, 5'd0, 1'b0, 32'd0); exp_rc(6'd1);
        tick(); step = 19; clr(); rd(0, 5'd7, 1'b1, 32'd6); rd(3, 5'd0, 1'b0, 32'd0); exp_rc(6'd1);

        // Reset mid-operation discards in-flight rename and commit
        tick(); step = 20; clr(); rst = 1'b0; ren(5'd9, 5'd1); cmt(5'd7, 5'd6, 32'h77);
        rd(0, 5'd7, 1'b0, 32'd0); exp_rc(6'd1);
        tick(); step = 21; clr(); rst = 1'b1;
        rd(0, 5'd7, 1'b0, 32'd0); rd(1, 5'd9, 1'b0, 32'd0); rd(2, 5'd2, 1'b0, 32'd0); exp_rc(6'd0);

`ifdef RRF_CHECKPOINT_EN
        // Checkpoint save, further rename, restore
        tick(); step = 22; clr(); ren(5'd8, 5'd1); exp_rc(6'd0);
        tick(); step = 23; clr(); bus.ckpt_save = 1'b1; exp_rc(6'd1);
        tick(); step = 24; clr(); ren(5'd9, 5'd2); exp_rc(6'd1);
        tick(); step = 25; clr(); bus.ckpt_restore = 1'b1;
        rd(0, 5'd8, 1'b1, 32'd1); rd(1, 5'd9, 1'b0, 32'd0); exp_rc(6'd2);
        tick(); step = 26; clr(); rd(0, 5'd8, 1'b1, 32'd1); rd(1, 5'd9, 1'b0, 32'd0); exp_rc(6'd1);
`endif

        tick(); step = 99; clr();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL have parameter NUM_READ, default 4, number of read ports (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register value width.
REQ-003 SHALL have parameter ROB_ADDR_WIDTH, default 5, ROB id width (< DATA_WIDTH).
REQ-004 SHALL have ports: clk input 1, clock; rst input 1, synchronous active-low reset.
REQ-005 SHALL have ports: ren_en in 1, ren_addr in 5, ren_id in ROB_ADDR_WIDTH (rename: mark register pending on ROB id).
REQ-006 SHALL have ports: cmt_en in 1, cmt_addr in 5, cmt_id in ROB_ADDR_WIDTH, cmt_data in DATA_WIDTH (commit from ROB head).
REQ-007 SHALL have port flush input 1, mispredict/exception recovery.
REQ-008 SHALL have ports: rd_en in NUM_READ, rd_addr in 5*NUM_READ, rd_is_ref out NUM_READ, rd_data out DATA_WIDTH*NUM_READ; port i occupies slice i.
REQ-009 SHALL have port ref_count output 6, registered count of registers currently pending.

Function
REQ-010 SHALL hold per register r (1..31): value, is_ref bit, ref_id; register 0 reads value 0, is_ref 0, writes to it are ignored.
REQ-011 Rename SHALL set is_ref[ren_addr]=1, ref_id[ren_addr]=ren_id at the clock edge when ren_en and no flush.
REQ-012 Commit SHALL write value[cmt_addr]=cmt_data at the edge when cmt_en, regardless of flush.
REQ-013 Commit SHALL clear is_ref[cmt_addr] only if is_ref set and ref_id==cmt_id; stale ids leave is_ref unchanged.
REQ-014 Rename and commit to same address in one cycle: value written, is_ref/ref_id take the rename.
REQ-015 flush SHALL clear every is_ref at the edge and discard a same-cycle rename.
REQ-016 Reads SHALL be combinational, zero latency; rd_en[i]=0 drives rd_is_ref[i]=0, rd_data[i]=0.
REQ-017 Read forwarding priority: addr 0 -> (0,0); flush -> (0, cmt_data if commit to same addr else stored value); rename same addr -> (1, ren_id zero-extended); commit same addr with matching pending id -> (0, cmt_data); else stored state.
REQ-018 Stored pending state SHALL read as rd_is_ref=1, rd_data=ref_id zero-extended; else value with rd_is_ref=0.
REQ-019 ref_count SHALL equal the population of is_ref after each edge (0..31), updated one cycle after the causing event.

Reset
REQ-020 While rst=0 at an edge: all values, is_ref, ref_id and ref_count SHALL become 0; ren/cmt/flush ignored.
REQ-021 While rst=0 all rd_is_ref and rd_data outputs SHALL be 0 combinationally.
REQ-022 Reset mid-operation SHALL discard any in-flight rename/commit of that cycle.

Configuration
REQ-023 Macro RRF_CHECKPOINT_EN SHALL add ports ckpt_save in 1 and ckpt_restore in 1 and a single shadow copy of is_ref/ref_id.
REQ-024 With it: ckpt_save captures the post-edge is_ref/ref_id table; commits matching a shadow ref_id also clear shadow is_ref; ckpt_restore (overrides flush) loads shadow into the live table at the edge, reads forward shadow state; reset clears shadow.
REQ-025 Without it: ports and shadow absent; flush is the only recovery, behaviour per REQ-015.

Verification
REQ-026 Reset, read r5 on all ports -> rd_is_ref=0, rd_data=0, ref_count=0.
REQ-027 Rename r3 id 7; same cycle read r3 -> (1,7); next cycle ref_count=1; commit r3 id 7 data 0xDEAD -> same-cycle read (0,0xDEAD), next ref_count=0.
REQ-028 Rename r4 id 2, rename r4 id 9, commit r4 id 2 data 0x11 -> r4 reads (1,9), value 0x11 hidden, ref_count=1.
REQ-029 Rename r1,r2,r3; flush with commit r2 id matching data 0x55 and rename r6 -> r1..r3,r6 read not-ref, r2=0x55, ref_count=0.
REQ-030 Rename and commit to r0, read r0 on port 3 -> (0,0), ref_count unchanged.
REQ-031 With RRF_CHECKPOINT_EN: rename r8 id 1, save, rename r9 id 2, restore -> r8 (1,1), r9 not-ref, ref_count=1.
